// File: rtl/uart_cmd_pkg.sv
// Shared types, ASCII constants and hex decode helper for the UART command parser.
// Lowercase acceptance is selected with the UART_CMD_LOWER_EN macro.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_TERM,
        ST_HOLD
    } state_t;

    localparam logic [7:0] ASC_CR = 8'h0D;
    localparam logic [7:0] ASC_LF = 8'h0A;
    localparam logic [7:0] ASC_W  = 8'h57;
    localparam logic [7:0] ASC_R  = 8'h52;
    localparam logic [7:0] ASC_LW = 8'h77;
    localparam logic [7:0] ASC_LR = 8'h72;

    // Returns {valid, nibble}; lowercase a-f only when lower_en is set.
    function automatic logic [4:0] hex2nib(input logic [7:0] b,
                                           input logic       lower_en);
        logic [4:0] r;
        r = 5'd0;
        if (b >= 8'h30 && b <= 8'h39)
            r = {1'b1, b[3:0]};
        else if (b >= 8'h41 && b <= 8'h46)
            r = {1'b1, 4'(b[3:0] + 4'd9)};
        else if (lower_en && b >= 8'h61 && b <= 8'h66)
            r = {1'b1, 4'(b[3:0] + 4'd9)};
        return r;
    endfunction

endpackage

// File: rtl/uart_cmd_hexdec.sv
// Combinational ASCII hex digit decoder: byte -> {valid, nibble}.
// Accepts lowercase a-f when UART_CMD_LOWER_EN is defined.
module uart_cmd_hexdec
    import uart_cmd_pkg::*;
(
    input  logic [7:0] rx_byte,
    output logic       vld,
    output logic [3:0] nib
);

`ifdef UART_CMD_LOWER_EN
    localparam logic LOWER = 1'b1;
`else
    localparam logic LOWER = 1'b0;
`endif

    assign {vld, nib} = hex2nib(rx_byte, LOWER);

endmodule

// File: rtl/uart_cmd_parser.sv
// ASCII hex command parser (W<addr><data><term> / R<addr><term>) behind a UART.
// UART_CMD_LOWER_EN: accept lowercase command letters and hex digits.
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned TOUT_CYC = 1000000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [7:0]        RX_Q,
    input  logic              RX_STB,
    output logic              CMD_VLD,
    output logic              CMD_WR,
    output logic [ADDR_W-1:0] CMD_ADDR,
    output logic [DATA_W-1:0] CMD_DATA,
    input  logic              CMD_ACK,
    output logic              ERR_STB,
    output logic              OVR_STB
);

`ifdef UART_CMD_LOWER_EN
    localparam logic LOWER = 1'b1;
`else
    localparam logic LOWER = 1'b0;
`endif

    localparam int NA   = ADDR_W / 4;
    localparam int ND   = DATA_W / 4;
    localparam int NMAX = (NA > ND) ? NA : ND;
    localparam int DCW  = $clog2(NMAX + 1);
    localparam int CW   = (TOUT_CYC > 1) ? $clog2(TOUT_CYC + 1) : 1;

    localparam logic [DCW-1:0] NA_M1   = DCW'(NA - 1);
    localparam logic [DCW-1:0] ND_M1   = DCW'(ND - 1);
    localparam logic [CW-1:0]  TOUT_M1 = CW'((TOUT_CYC > 0) ? TOUT_CYC - 1 : 0);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic              wr_q,    wr_d;
    logic              vld_q,   vld_d;
    logic              err_q,   err_d;
    logic              ovr_q,   ovr_d;
    logic [DCW-1:0]    dig_q,   dig_d;
    logic [CW-1:0]     tcnt_q,  tcnt_d;

    logic       hex_vld;
    logic [3:0] hex_nib;
    logic       is_w, is_r, is_term, counting, tout_hit;

    uart_cmd_hexdec u_hexdec (
        .rx_byte (RX_Q),
        .vld     (hex_vld),
        .nib     (hex_nib)
    );

    assign is_w     = (RX_Q == ASC_W) || (LOWER && RX_Q == ASC_LW);
    assign is_r     = (RX_Q == ASC_R) || (LOWER && RX_Q == ASC_LR);
    assign is_term  = (RX_Q == ASC_CR) || (RX_Q == ASC_LF);
    assign counting = (state_q == ST_ADDR) || (state_q == ST_DATA) ||
                      (state_q == ST_TERM);
    assign tout_hit = (TOUT_CYC != 0) && counting && !RX_STB &&
                      (tcnt_q == TOUT_M1);

    // Next-state, shift registers, strobes and inter-byte timeout counter.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wr_d    = wr_q;
        vld_d   = vld_q;
        err_d   = 1'b0;
        ovr_d   = 1'b0;
        dig_d   = dig_q;
        tcnt_d  = '0;
        if (TOUT_CYC != 0 && counting && !RX_STB)
            tcnt_d = tcnt_q + 1'b1;
        unique case (state_q)
            ST_IDLE: begin
                if (RX_STB) begin
                    if (is_w || is_r) begin
                        state_d = ST_ADDR;
                        addr_d  = '0;
                        data_d  = '0;
                        wr_d    = is_w;
                        dig_d   = '0;
                    end else if (!is_term) begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_ADDR: begin
                if (RX_STB) begin
                    if (hex_vld) begin
                        addr_d = (addr_q << 4) | ADDR_W'(hex_nib);
                        dig_d  = dig_q + 1'b1;
                        if (dig_q == NA_M1) begin
                            dig_d   = '0;
                            state_d = wr_q ? ST_DATA : ST_TERM;
                        end
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (RX_STB) begin
                    if (hex_vld) begin
                        data_d = (data_q << 4) | DATA_W'(hex_nib);
                        dig_d  = dig_q + 1'b1;
                        if (dig_q == ND_M1) begin
                            dig_d   = '0;
                            state_d = ST_TERM;
                        end
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_TERM: begin
                if (RX_STB) begin
                    if (is_term) begin
                        state_d = ST_HOLD;
                        vld_d   = 1'b1;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_HOLD: begin
                if (RX_STB)
                    ovr_d = 1'b1;
                if (vld_q && CMD_ACK) begin
                    vld_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (tout_hit) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
        end
    end

    // State and output registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            wr_q    <= 1'b0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
            ovr_q   <= 1'b0;
            dig_q   <= '0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
            ovr_q   <= ovr_d;
            dig_q   <= dig_d;
            tcnt_q  <= tcnt_d;
        end
    end

    assign CMD_VLD  = vld_q;
    assign CMD_WR   = wr_q;
    assign CMD_ADDR = addr_q;
    assign CMD_DATA = data_q;
    assign ERR_STB  = err_q;
    assign OVR_STB  = ovr_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed testbench for uart_cmd_parser.
// Build with or without +define+UART_CMD_LOWER_EN.
module tb_uart_cmd_parser;

    localparam int TOUT = 50;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] RX_Q = 8'h00;
    logic       RX_STB = 1'b0;
    logic       CMD_ACK = 1'b0;
    logic       CMD_VLD, CMD_WR, ERR_STB, OVR_STB;
    logic [7:0] CMD_ADDR, CMD_DATA;

    int tests = 0;
    int fails = 0;
    int err_n = 0;
    int ovr_n = 0;
    int acc_n = 0;
    int vld_cyc = 0;
    logic       cap_wr;
    logic [7:0] cap_addr, cap_data;

    uart_cmd_parser #(
        .ADDR_W   (8),
        .DATA_W   (8),
        .TOUT_CYC (TOUT)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .RX_Q     (RX_Q),
        .RX_STB   (RX_STB),
        .CMD_VLD  (CMD_VLD),
        .CMD_WR   (CMD_WR),
        .CMD_ADDR (CMD_ADDR),
        .CMD_DATA (CMD_DATA),
        .CMD_ACK  (CMD_ACK),
        .ERR_STB  (ERR_STB),
        .OVR_STB  (OVR_STB)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (ERR_STB) err_n++;
        if (OVR_STB) ovr_n++;
        if (CMD_VLD) vld_cyc++;
        if (CMD_VLD && CMD_ACK) begin
            acc_n++;
            cap_wr   = CMD_WR;
            cap_addr = CMD_ADDR;
            cap_data = CMD_DATA;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clr();
        err_n = 0; ovr_n = 0; acc_n = 0; vld_cyc = 0;
        cap_wr = 1'bx; cap_addr = 8'hxx; cap_data = 8'hxx;
    endtask

    task automatic wait_cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK); #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge CLK); #1;
        RX_Q = b; RX_STB = 1'b1;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic idle_bus();
        @(posedge CLK); #1;
        RX_STB = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        tests++; if (CMD_VLD !== 1'b0) begin fails++;
            $display("FAIL rst_vld got %0b want 0", CMD_VLD); end
        tests++; if (CMD_WR !== 1'b0) begin fails++;
            $display("FAIL rst_wr got %0b want 0", CMD_WR); end
        tests++; if (CMD_ADDR !== 8'h00) begin fails++;
            $display("FAIL rst_addr got %0h want 0", CMD_ADDR); end
        tests++; if (CMD_DATA !== 8'h00) begin fails++;
            $display("FAIL rst_data got %0h want 0", CMD_DATA); end
        tests++; if ({ERR_STB, OVR_STB} !== 2'b00) begin fails++;
            $display("FAIL rst_strobes got %0b want 00", {ERR_STB, OVR_STB}); end
        wait_cyc(2);
        RST = 1'b0;
        wait_cyc(2);
    endtask

    task automatic test_write();
        clr();
        CMD_ACK = 1'b1;
        send_str("W1A5C"); send_byte(8'h0D); idle_bus();
        wait_cyc(4);
        CMD_ACK = 1'b0;
        tests++; if (acc_n !== 1) begin fails++;
            $display("FAIL wr_count got %0d want 1", acc_n); end
        tests++; if (vld_cyc !== 1) begin fails++;
            $display("FAIL wr_vld_cycles got %0d want 1", vld_cyc); end
        tests++; if ({cap_wr, cap_addr, cap_data} !== {1'b1, 8'h1A, 8'h5C}) begin
            fails++;
            $display("FAIL wr_cmd got wr=%0b a=%0h d=%0h want 1/1a/5c",
                     cap_wr, cap_addr, cap_data); end
        tests++; if (err_n + ovr_n !== 0) begin fails++;
            $display("FAIL wr_strobes got err=%0d ovr=%0d want 0/0", err_n, ovr_n); end
    endtask

    task automatic test_read_hold();
        clr();
        CMD_ACK = 1'b0;
        send_str("R7F"); send_byte(8'h0D); send_byte(8'h0A); idle_bus();
        wait_cyc(10);
        tests++; if ({CMD_VLD, CMD_WR} !== 2'b10) begin fails++;
            $display("FAIL rd_hold got vld/wr=%0b want 10", {CMD_VLD, CMD_WR}); end
        tests++; if ({CMD_ADDR, CMD_DATA} !== 16'h7F00) begin fails++;
            $display("FAIL rd_fields got %0h want 7f00", {CMD_ADDR, CMD_DATA}); end
        tests++; if (ovr_n !== 1) begin fails++;
            $display("FAIL rd_ovr got %0d want 1", ovr_n); end
        CMD_ACK = 1'b1;
        wait_cyc(1);
        CMD_ACK = 1'b0;
        wait_cyc(2);
        tests++; if (acc_n !== 1 || CMD_VLD !== 1'b0) begin fails++;
            $display("FAIL rd_ack got acc=%0d vld=%0b want 1/0", acc_n, CMD_VLD); end
        tests++; if (vld_cyc < 10) begin fails++;
            $display("FAIL rd_vld_cycles got %0d want >=10", vld_cyc); end
        tests++; if (err_n !== 0) begin fails++;
            $display("FAIL rd_err got %0d want 0", err_n); end
    endtask

    task automatic test_syntax_err();
        clr();
        CMD_ACK = 1'b1;
        send_str("W1G"); idle_bus();
        wait_cyc(2);
        tests++; if (err_n !== 1) begin fails++;
            $display("FAIL syn_err got %0d want 1", err_n); end
        send_str("R00"); send_byte(8'h0D); idle_bus();
        wait_cyc(3);
        CMD_ACK = 1'b0;
        tests++; if (acc_n !== 1 || {cap_wr, cap_addr, cap_data} !== 17'h0) begin
            fails++;
            $display("FAIL syn_recover got acc=%0d wr=%0b a=%0h d=%0h want 1/0/0/0",
                     acc_n, cap_wr, cap_addr, cap_data); end
        tests++; if (err_n !== 1) begin fails++;
            $display("FAIL syn_err_total got %0d want 1", err_n); end
    endtask

    task automatic test_timeout();
        clr();
        send_str("W12"); idle_bus();
        wait_cyc(TOUT - 3);
        tests++; if (err_n !== 0) begin fails++;
            $display("FAIL tout_early got %0d want 0", err_n); end
        wait_cyc(13);
        tests++; if (err_n !== 1) begin fails++;
            $display("FAIL tout_err got %0d want 1", err_n); end
        CMD_ACK = 1'b1;
        send_str("W0102"); send_byte(8'h0A); idle_bus();
        wait_cyc(3);
        CMD_ACK = 1'b0;
        tests++; if (acc_n !== 1 || {cap_wr, cap_addr, cap_data} !== {1'b1, 16'h0102})
        begin fails++;
            $display("FAIL tout_recover got acc=%0d wr=%0b a=%0h d=%0h want 1/1/01/02",
                     acc_n, cap_wr, cap_addr, cap_data); end
    endtask

    task automatic test_lower();
        clr();
        CMD_ACK = 1'b1;
        send_str("w0a0b"); send_byte(8'h0D); idle_bus();
        wait_cyc(3);
        CMD_ACK = 1'b0;
`ifdef UART_CMD_LOWER_EN
        tests++; if (acc_n !== 1 || {cap_wr, cap_addr, cap_data} !== {1'b1, 16'h0A0B})
        begin fails++;
            $display("FAIL lower_cmd got acc=%0d wr=%0b a=%0h d=%0h want 1/1/0a/0b",
                     acc_n, cap_wr, cap_addr, cap_data); end
        tests++; if (err_n !== 0) begin fails++;
            $display("FAIL lower_err got %0d want 0", err_n); end
`else
        tests++; if (acc_n !== 0) begin fails++;
            $display("FAIL lower_cmd got acc=%0d want 0", acc_n); end
        tests++; if (err_n !== 5) begin fails++;
            $display("FAIL lower_err got %0d want 5", err_n); end
`endif
    endtask

    task automatic test_back_to_back();
        clr();
        CMD_ACK = 1'b1;
        send_str("R01"); send_byte(8'h0D);
        send_str("R02"); send_byte(8'h0D); idle_bus();
        wait_cyc(3);
        CMD_ACK = 1'b0;
        tests++; if (acc_n !== 1 || cap_addr !== 8'h01) begin fails++;
            $display("FAIL b2b_cmd got acc=%0d a=%0h want 1/01", acc_n, cap_addr); end
        tests++; if (ovr_n !== 1) begin fails++;
            $display("FAIL b2b_ovr got %0d want 1", ovr_n); end
        tests++; if (err_n !== 2) begin fails++;
            $display("FAIL b2b_err got %0d want 2", err_n); end
    endtask

    task automatic test_reset_mid();
        clr();
        send_str("W12"); idle_bus();
        RST = 1'b1;
        #2;
        tests++; if ({CMD_VLD, CMD_WR, CMD_ADDR, CMD_DATA, ERR_STB, OVR_STB} !== 20'h0)
        begin fails++;
            $display("FAIL rstmid_outs got vld=%0b wr=%0b a=%0h d=%0h e=%0b o=%0b want 0",
                     CMD_VLD, CMD_WR, CMD_ADDR, CMD_DATA, ERR_STB, OVR_STB); end
        wait_cyc(2);
        RST = 1'b0;
        wait_cyc(1);
        CMD_ACK = 1'b1;
        send_str("R34"); send_byte(8'h0D); idle_bus();
        wait_cyc(3);
        CMD_ACK = 1'b0;
        tests++; if (acc_n !== 1 || {cap_wr, cap_addr, cap_data} !== {1'b0, 16'h3400})
        begin fails++;
            $display("FAIL rstmid_cmd got acc=%0d wr=%0b a=%0h d=%0h want 1/0/34/00",
                     acc_n, cap_wr, cap_addr, cap_data); end
        tests++; if (err_n + ovr_n !== 0) begin fails++;
            $display("FAIL rstmid_strobes got err=%0d ovr=%0d want 0/0", err_n, ovr_n); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_hold();
        test_syntax_err();
        test_timeout();
        test_lower();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
